// File: rtl/dynamic_adder_ctrl_if.sv
// Handshake and adder-side bus of the dynamic adder controller.
// slave = the controller, master = producer/consumer/adder environment.
interface dynamic_adder_ctrl_if #(
  parameter int N = 16
);
  localparam int CW = $clog2(2*N+3);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    out_sum;
  logic [CW-1:0] out_cycles;
  logic          busy;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic          add_cin;
  logic [N-1:0]  add_p;
  logic [N-1:0]  add_s;
  logic          add_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_p, add_s, add_cout,
    output in_ready, out_valid, out_sum, out_cycles, busy, add_a, add_b, add_cin
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_p, add_s, add_cout,
    input  in_ready, out_valid, out_sum, out_cycles, busy, add_a, add_b, add_cin
  );
endinterface

// File: rtl/dynamic_adder_ctrl.sv
// Runs an external ripple-carry adder with a wait sized to its longest carry chain.
// Define STATS_EN to add saturating op_count / wait_total outputs.
module dynamic_adder_ctrl #(
  parameter int N                = 16,
  parameter int DELAYS_PER_CYCLE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dynamic_adder_ctrl_if.slave bus
`ifdef STATS_EN
  ,
  output logic [31:0]         op_count,
  output logic [31:0]         wait_total
`endif
);

  localparam int CW = $clog2(2*N+3);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  add_a_q, add_a_d;
  logic [N-1:0]  add_b_q, add_b_d;
  logic          add_cin_q, add_cin_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [N:0]    out_sum_q, out_sum_d;
  logic [CW-1:0] out_cycles_q, out_cycles_d;
  int            run_len;
  int            longest;
  logic [CW-1:0] launch_w;

  // A run of L propagating bits costs 2*(L+1) gate delays before the carry settles.
  always_comb begin
    run_len = 0;
    longest = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.add_p[i]) run_len = run_len + 1;
      else              run_len = 0;
      if (run_len > longest) longest = run_len;
    end
  end

  assign launch_w = CW'((2*longest + 1 + DELAYS_PER_CYCLE) / DELAYS_PER_CYCLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (counter_q == CW'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.busy       = (state_q != IDLE);
    bus.out_valid  = (state_q == DONE);
    bus.out_sum    = out_sum_q;
    bus.out_cycles = out_cycles_q;
    bus.add_a      = add_a_q;
    bus.add_b      = add_b_q;
    bus.add_cin    = add_cin_q;
  end

  always_comb begin
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    counter_d    = counter_q;
    out_sum_d    = out_sum_q;
    out_cycles_d = out_cycles_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          add_a_d   = bus.in_a;
          add_b_d   = bus.in_b;
          add_cin_d = bus.in_cin;
        end
      end
      LAUNCH: begin
        counter_d    = launch_w;
        out_cycles_d = launch_w;
      end
      WAIT: begin
        counter_d = counter_q - CW'(1);
        if (counter_q == CW'(1)) out_sum_d = {bus.add_cout, bus.add_s};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cin_q    <= 1'b0;
      counter_q    <= '0;
      out_sum_q    <= '0;
      out_cycles_q <= '0;
    end else begin
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      counter_q    <= counter_d;
      out_sum_q    <= out_sum_d;
      out_cycles_q <= out_cycles_d;
    end
  end

`ifdef STATS_EN
  logic [31:0] op_count_q, op_count_d;
  logic [31:0] wait_total_q, wait_total_d;
  logic [32:0] wait_sum;

  // Both totals saturate rather than wrap so long runs stay monotonic.
  always_comb begin
    op_count_d   = op_count_q;
    wait_total_d = wait_total_q;
    wait_sum     = {1'b0, wait_total_q} + 33'(out_cycles_q);
    if (state_q == DONE && bus.out_ready) begin
      if (op_count_q != 32'hFFFF_FFFF) op_count_d = op_count_q + 32'd1;
      wait_total_d = wait_sum[32] ? 32'hFFFF_FFFF : wait_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q   <= '0;
      wait_total_q <= '0;
    end else begin
      op_count_q   <= op_count_d;
      wait_total_q <= wait_total_d;
    end
  end

  assign op_count   = op_count_q;
  assign wait_total = wait_total_q;
`endif

endmodule

// File: tb/tb_dynamic_adder_ctrl.sv
// Directed plus random bench for dynamic_adder_ctrl against a reference model
// of A+B+Cin and the carry-chain wait count.
module tb_dynamic_adder_ctrl;

  localparam int N   = 16;
  localparam int DPC = 8;
  localparam int CW  = $clog2(2*N+3);

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   opCount;
  int   waitSum;

  dynamic_adder_ctrl_if #(.N(N)) bus ();

`ifdef STATS_EN
  logic [31:0] op_count;
  logic [31:0] wait_total;
`endif

  dynamic_adder_ctrl #(.N(N), .DELAYS_PER_CYCLE(DPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STATS_EN
    ,
    .op_count   (op_count),
    .wait_total (wait_total)
`endif
  );

  // Combinational ripple-carry adder seen by the controller.
  assign bus.add_p = bus.add_a ^ bus.add_b;
  assign {bus.add_cout, bus.add_s} = bus.add_a + bus.add_b + bus.add_cin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Longest run of ones: each AND with a shifted copy shortens every run by one.
  function automatic int refLongestRun(input logic [N-1:0] p);
    logic [N-1:0] x;
    int n;
    x = p;
    n = 0;
    while (x != '0) begin
      x = x & (x >> 1);
      n++;
    end
    return n;
  endfunction

  function automatic int refWait(input logic [N-1:0] p);
    int d;
    int w;
    d = 2 * (refLongestRun(p) + 1);
    w = (d + DPC - 1) / DPC;
    return (w < 1) ? 1 : w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      stepClock();
      guard++;
    end
    checkOutput("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    stepClock();
    bus.in_valid = 1'b0;
    bus.in_a     = N'($urandom);
    bus.in_b     = N'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input int hold);
    logic [N:0] expSum;
    int         expW;
    int         edges;
    expSum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    expW   = refWait(a ^ b);
    applyStimulus(a, b, cin);
    edges = 1;
    while (!bus.out_valid && edges < 64) begin
      bus.out_ready = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.in_a      = N'($urandom);
      stepClock();
      edges++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("latency_edges", 64'(edges), 64'(expW + 2));
    checkOutput("out_sum", 64'(bus.out_sum), 64'(expSum));
    checkOutput("out_cycles", 64'(bus.out_cycles), 64'(expW));
    checkOutput("add_operands_stable", {bus.add_cin, bus.add_b, bus.add_a}, {cin, b, a});
    checkOutput("in_ready_in_done", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      stepClock();
      checkOutput("hold_out_valid", bus.out_valid, 1);
      checkOutput("hold_out_sum", 64'(bus.out_sum), 64'(expSum));
      checkOutput("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    stepClock();
    bus.out_ready = 1'b0;
    checkOutput("idle_after_accept", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    opCount++;
    waitSum += expW;
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    errors        = 0;
    checks        = 0;
    opCount       = 0;
    waitSum       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) stepClock();
    checkOutput("reset_ctrl", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    checkOutput("reset_out_sum", 64'(bus.out_sum), 0);
    checkOutput("reset_out_cycles", 64'(bus.out_cycles), 0);
    checkOutput("reset_add", {bus.add_cin, bus.add_b, bus.add_a}, 0);
    rst_n = 1'b1;
    stepClock();

    $display("[TB] case 1: all zero operands");
    runOp(16'h0000, 16'h0000, 1'b0, 0);
    checkOutput("case1_cycles", 64'(bus.out_cycles), 1);
    checkOutput("case1_sum", 64'(bus.out_sum), 64'h0_0000);

    $display("[TB] case 2/4: P=FFFE with 10-cycle consumer stall");
    runOp(16'hFFFF, 16'h0001, 1'b0, 10);
    checkOutput("case2_cycles", 64'(bus.out_cycles), 4);
    checkOutput("case2_sum", 64'(bus.out_sum), 64'h1_0000);

    $display("[TB] case 3: P all ones");
    runOp(16'h00FF, 16'hFF00, 1'b1, 0);
    checkOutput("case3_cycles", 64'(bus.out_cycles), 5);
    checkOutput("case3_sum", 64'(bus.out_sum), 64'h1_0000);

    $display("[TB] case 5: reset during WAIT");
    applyStimulus(16'h00FF, 16'hFF00, 1'b1);
    stepClock();
    stepClock();
    checkOutput("case5_busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("case5_ctrl", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    checkOutput("case5_out_sum", 64'(bus.out_sum), 0);
    checkOutput("case5_out_cycles", 64'(bus.out_cycles), 0);
    checkOutput("case5_add", {bus.add_cin, bus.add_b, bus.add_a}, 0);
    opCount = 0;
    waitSum = 0;
    stepClock();
    rst_n = 1'b1;
    stepClock();
    checkOutput("case5_no_result", bus.out_valid, 0);
    runOp(16'h0000, 16'h0000, 1'b0, 0);
    checkOutput("case5_recover_cycles", 64'(bus.out_cycles), 1);

    $display("[TB] case 6: random operations");
    for (int k = 0; k < 2000; k++) begin
      ra = N'($urandom);
      if ($urandom_range(0, 2) == 0) rb = ~ra ^ N'(1 << $urandom_range(0, N-1));
      else                           rb = N'($urandom);
      runOp(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

`ifdef STATS_EN
    checkOutput("stats_op_count", 64'(op_count), 64'(opCount));
    checkOutput("stats_wait_total", 64'(wait_total), 64'(waitSum));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
